// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit
// Description : Multi-cycle multiply/divide engine next to the EX stage.
//               Computes {HI,LO} for MULT/MULTU/DIV/DIVU (and MADD/MADDU/
//               MSUB/MSUBU). Shift-add multiply and restoring divide, UNROLL
//               bits per iteration, N = WIDTH/UNROLL iterations.
//               Optional build macro: MULDIV_ACC_EN enables accumulation of
//               ops 4-7 into {hi_i,lo_i}; without it ops 4/6 behave as MULT
//               and ops 5/7 as MULTU.
// Ports       : clk, rst (async, active-low)
//               start_i, op_i[2:0], opa_i, opb_i, hi_i, lo_i, cancel_i
//               busy_o, stall_req_o, done_o, hi_o, lo_o, div_zero_o
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             stall_req_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  localparam int N  = WIDTH / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_CNT_INIT = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_p;        // multiply: {hi,lo}; divide: {rem,quo}
  logic [WIDTH-1:0]   r_m;        // multiplicand or divisor magnitude
  logic               r_is_div, r_dz, r_neg_q, r_neg_r;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_dzo;

  logic               w_idle, w_accept, w_op_div, w_op_sgn, w_dz;
  logic [WIDTH-1:0]   w_a_abs, w_b_abs;
  logic [2*WIDTH-1:0] w_step, w_prod, w_res;
  logic [WIDTH:0]     w_upper, w_rem_sh, w_diff;
  logic [WIDTH-1:0]   w_quo, w_rem;

`ifdef MULDIV_ACC_EN
  logic               r_acc_en, r_acc_sub;
  logic [WIDTH-1:0]   r_acc_hi, r_acc_lo;
`else
  logic               w_unused_acc;
  assign w_unused_acc = ^{hi_i, lo_i};
`endif

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = start_i & w_idle & ~cancel_i;
  assign w_op_div = (op_i[2:1] == 2'b01);
  assign w_op_sgn = ~op_i[0];     // even opcodes are the signed variants
  assign w_dz     = w_op_div & (opb_i == '0);
  assign w_a_abs  = (w_op_sgn & opa_i[WIDTH-1]) ? (~opa_i + 1'b1) : opa_i;
  assign w_b_abs  = (w_op_sgn & opb_i[WIDTH-1]) ? (~opb_i + 1'b1) : opb_i;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_dz ? S_FIX : S_CALC;
      S_CALC: begin
        if (cancel_i)            w_state_nxt = S_IDLE;
        else if (r_cnt == '0)    w_state_nxt = S_FIX;
      end
      S_FIX:  w_state_nxt = cancel_i ? S_IDLE : S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy_o = (r_state != S_IDLE);
    done_o = (r_state == S_DONE);
  end

  assign stall_req_o = (start_i & w_idle & ~cancel_i) | (busy_o & ~done_o);
  assign hi_o        = r_hi;
  assign lo_o        = r_lo;
  assign div_zero_o  = r_dzo;

  // One CALC cycle: UNROLL shift-add or restoring-divide steps
  always_comb begin
    w_step   = r_p;
    w_upper  = '0;
    w_rem_sh = '0;
    w_diff   = '0;
    for (int u = 0; u < UNROLL; u++) begin
      if (r_is_div) begin
        w_rem_sh = {w_step[2*WIDTH-1:WIDTH], w_step[WIDTH-1]};
        w_diff   = w_rem_sh - {1'b0, r_m};
        // Borrow out of the trial subtraction means the divisor did not fit
        if (!w_diff[WIDTH]) w_step = {w_diff[WIDTH-1:0], w_step[WIDTH-2:0], 1'b1};
        else                w_step = {w_rem_sh[WIDTH-1:0], w_step[WIDTH-2:0], 1'b0};
      end else begin
        w_upper = {1'b0, w_step[2*WIDTH-1:WIDTH]} + (w_step[0] ? {1'b0, r_m} : '0);
        w_step  = {w_upper, w_step[WIDTH-1:1]};
      end
    end
  end

  // Sign fix-up and optional accumulate
  always_comb begin
    w_prod = r_neg_q ? (~r_p + 1'b1) : r_p;
    w_quo  = r_neg_q ? (~r_p[WIDTH-1:0] + 1'b1) : r_p[WIDTH-1:0];
    w_rem  = r_neg_r ? (~r_p[2*WIDTH-1:WIDTH] + 1'b1) : r_p[2*WIDTH-1:WIDTH];
    if (r_dz)          w_res = r_p;   // preloaded {dividend, all ones}
    else if (r_is_div) w_res = {w_rem, w_quo};
    else begin
      w_res = w_prod;
`ifdef MULDIV_ACC_EN
      if (r_acc_en)
        w_res = r_acc_sub ? ({r_acc_hi, r_acc_lo} - w_prod) : ({r_acc_hi, r_acc_lo} + w_prod);
`endif
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_p      <= '0;
      r_m      <= '0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dzo    <= 1'b0;
`ifdef MULDIV_ACC_EN
      r_acc_en  <= 1'b0;
      r_acc_sub <= 1'b0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_is_div <= w_op_div;
        r_dz     <= w_dz;
        r_cnt    <= C_CNT_INIT;
        r_neg_q  <= w_op_sgn & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
        r_neg_r  <= w_op_sgn & opa_i[WIDTH-1];
        r_m      <= w_op_div ? w_b_abs : w_a_abs;
        if (w_dz)          r_p <= {opa_i, {WIDTH{1'b1}}};
        else if (w_op_div) r_p <= {{WIDTH{1'b0}}, w_a_abs};
        else               r_p <= {{WIDTH{1'b0}}, w_b_abs};
`ifdef MULDIV_ACC_EN
        r_acc_en  <= op_i[2];
        r_acc_sub <= op_i[1];
        r_acc_hi  <= hi_i;
        r_acc_lo  <= lo_i;
`endif
      end else if (r_state == S_CALC) begin
        r_p   <= w_step;
        r_cnt <= r_cnt - CW'(1);
      end
      // Results become visible exactly when the FSM enters DONE
      if ((r_state == S_FIX) && !cancel_i) begin
        r_hi  <= w_res[2*WIDTH-1:WIDTH];
        r_lo  <= w_res[WIDTH-1:0];
        r_dzo <= r_dz;
      end
    end
  end

endmodule
`default_nettype wire
